cmd_arbiter: RTL and testbench

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter_pkg.sv | 27 ++
 rtl/cmd_arbiter_if.sv | 35 +++
 rtl/cmd_arb_pick.sv | 35 +++
 rtl/cmd_arbiter.sv | 143 ++++++++++++++
 tb/tb_cmd_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_arbiter_pkg.sv
// Shared types and constants for the command arbiter: FSM encoding, requester
// count, well-known command indices and the default watchdog limit.
package cmd_arbiter_pkg;

  localparam int          REQ_N                  = 3;
  localparam logic [5:0]  CMD12_INDEX            = 6'd12;
  localparam logic [5:0]  CMD23_INDEX            = 6'd23;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] oh_to_idx(input logic [REQ_N-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/cmd_arbiter_if.sv
// Requester and CMD_master signal bundle of the command arbiter.
// Handshake: a requester holds req until its done pulse; new_cmd is held until cmd_busy is seen.
interface cmd_arbiter_if;
  import cmd_arbiter_pkg::*;

  logic [REQ_N-1:0]      req;
  logic [6*REQ_N-1:0]    req_index;
  logic [32*REQ_N-1:0]   req_arg;
  logic [REQ_N-1:0]      gnt;
  logic [REQ_N-1:0]      done;
  logic [REQ_N-1:0]      err;
  logic [31:0]           rsp_arg;
  logic [5:0]            rsp_index;
  logic                  new_cmd;
  logic [5:0]            cmd_index;
  logic [31:0]           cmd_arg;
  logic                  cmd_busy;
  logic                  cmd_complete;
  logic                  timeout_error;
  logic [31:0]           response_arg;
  logic [5:0]            response_index;

  modport master (
    output req, req_index, req_arg, cmd_busy, cmd_complete, timeout_error,
           response_arg, response_index,
    input  gnt, done, err, rsp_arg, rsp_index, new_cmd, cmd_index, cmd_arg
  );

  modport slave (
    input  req, req_index, req_arg, cmd_busy, cmd_complete, timeout_error,
           response_arg, response_index,
    output gnt, done, err, rsp_arg, rsp_index, new_cmd, cmd_index, cmd_arg
  );

endinterface

// File: rtl/cmd_arb_pick.sv
// Combinational winner picker. CMD_ARB_ROUND_ROBIN_EN selects round-robin from
// i_ptr; otherwise fixed priority req[1] > req[2] > req[0].
module cmd_arb_pick import cmd_arbiter_pkg::*; (
  input  logic [REQ_N-1:0] i_req,
`ifdef CMD_ARB_ROUND_ROBIN_EN
  input  logic [1:0]       i_ptr,
`endif
  output logic [REQ_N-1:0] o_win
);

`ifdef CMD_ARB_ROUND_ROBIN_EN
  logic [REQ_N-1:0] w_rot;
  logic [REQ_N-1:0] w_oh;

  // Rotate so the search start sits at bit 0, pick lowest, rotate back.
  assign w_rot = 3'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_oh = '0;
    if (w_rot[0])      w_oh = 3'b001;
    else if (w_rot[1]) w_oh = 3'b010;
    else if (w_rot[2]) w_oh = 3'b100;
  end

  assign o_win = 3'(({w_oh, w_oh} << i_ptr) >> 3);
`else
  always_comb begin
    o_win = '0;
    if (i_req[1])      o_win = 3'b010;
    else if (i_req[2]) o_win = 3'b100;
    else if (i_req[0]) o_win = 3'b001;
  end
`endif

endmodule

// File: rtl/cmd_arbiter.sv
// Arbitrates three command requesters onto one CMD_master with a per-command watchdog.
// Optional macro CMD_ARB_ROUND_ROBIN_EN switches the picker to round-robin.
module cmd_arbiter import cmd_arbiter_pkg::*; #(
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         CLK_host,
  input  logic         reset,
  cmd_arbiter_if.slave if_arb,
  output state_t       o_dbg_state
);

  state_t           r_state;
  logic [REQ_N-1:0] r_gnt, r_done, r_err;
  logic             r_new_cmd;
  logic [5:0]       r_cmd_index, r_rsp_index;
  logic [31:0]      r_cmd_arg, r_rsp_arg;
  logic [15:0]      r_wd;
  logic [REQ_N-1:0] w_win;
  logic [1:0]       w_sel;
  logic [5:0]       w_index;
  logic [31:0]      w_arg;
  logic             w_expire;
`ifdef CMD_ARB_ROUND_ROBIN_EN
  logic [1:0]       r_ptr;
`endif

  cmd_arb_pick u_pick (
    .i_req (if_arb.req),
`ifdef CMD_ARB_ROUND_ROBIN_EN
    .i_ptr (r_ptr),
`endif
    .o_win (w_win)
  );

  assign w_sel = oh_to_idx(w_win);

  always_comb begin
    w_index = if_arb.req_index[5:0];
    w_arg   = if_arb.req_arg[31:0];
    case (w_sel)
      2'd1: begin
        w_index = if_arb.req_index[11:6];
        w_arg   = if_arb.req_arg[63:32];
      end
      2'd2: begin
        w_index = if_arb.req_index[17:12];
        w_arg   = if_arb.req_arg[95:64];
      end
      default: ;
    endcase
  end

  // Watchdog is cleared on ISSUE entry, so this fires TIMEOUT_CYCLES edges later.
  assign w_expire = (r_wd == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge CLK_host or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_new_cmd   <= 1'b0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_rsp_index <= '0;
      r_rsp_arg   <= '0;
      r_wd        <= '0;
`ifdef CMD_ARB_ROUND_ROBIN_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|if_arb.req) begin
            r_gnt       <= w_win;
            r_cmd_index <= w_index;
            r_cmd_arg   <= w_arg;
            r_new_cmd   <= 1'b1;
            r_wd        <= '0;
            r_state     <= ST_ISSUE;
`ifdef CMD_ARB_ROUND_ROBIN_EN
            r_ptr       <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
`endif
          end
        end
        ST_ISSUE: begin
          if (w_expire) begin
            r_new_cmd   <= 1'b0;
            r_done      <= r_gnt;
            r_err       <= r_gnt;
            r_rsp_index <= '0;
            r_rsp_arg   <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_wd <= r_wd + 16'd1;
            if (if_arb.cmd_busy) begin
              r_new_cmd <= 1'b0;
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A real completion beats a simultaneous watchdog expiry.
          if (if_arb.cmd_complete || if_arb.timeout_error) begin
            r_done      <= r_gnt;
            r_err       <= if_arb.timeout_error ? r_gnt : '0;
            r_rsp_index <= if_arb.response_index;
            r_rsp_arg   <= if_arb.response_arg;
            r_state     <= ST_DONE;
          end else if (w_expire) begin
            r_done      <= r_gnt;
            r_err       <= r_gnt;
            r_rsp_index <= '0;
            r_rsp_arg   <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        ST_DONE: begin
          r_done      <= '0;
          r_err       <= '0;
          r_rsp_index <= '0;
          r_rsp_arg   <= '0;
          r_gnt       <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_arb.gnt       = r_gnt;
  assign if_arb.done      = r_done;
  assign if_arb.err       = r_err;
  assign if_arb.rsp_arg   = r_rsp_arg;
  assign if_arb.rsp_index = r_rsp_index;
  assign if_arb.new_cmd   = r_new_cmd;
  assign if_arb.cmd_index = r_cmd_index;
  assign if_arb.cmd_arg   = r_cmd_arg;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: a vector table of complete commands plus
// hand-written sequences for timeout, race, reset and loser-change cases.
module tb_cmd_arbiter;
  import cmd_arbiter_pkg::*;

  localparam logic [15:0] TO = 16'd16;
  localparam int NV = 10;

  logic   CLK_host = 1'b0;
  logic   reset;
  state_t dbg_state;

  cmd_arbiter_if bus();

  cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK_host    (CLK_host),
    .reset       (reset),
    .if_arb      (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / global bound
  always #5 CLK_host = ~CLK_host;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  req;
    logic [17:0] req_index;
    logic [95:0] req_arg;
    int          busy_dly;
    int          cmpl_dly;
    logic        cc;
    logic        te;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic [2:0]  gnt_fixed;
    logic [2:0]  gnt_rr;
  } vec_t;

  vec_t       vecs [NV];
  logic [2:0] exp_q [$];
  int         n_vec;
  int         n_miscompare;

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] sel_idx(input logic [17:0] v, input logic [2:0] oh);
    case (oh)
      3'b001:  return v[5:0];
      3'b010:  return v[11:6];
      3'b100:  return v[17:12];
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] sel_arg(input logic [95:0] v, input logic [2:0] oh);
    case (oh)
      3'b001:  return v[31:0];
      3'b010:  return v[63:32];
      3'b100:  return v[95:64];
      default: return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic step();
    @(posedge CLK_host);
    #1;
  endtask

  task automatic drive_idle();
    bus.req            = '0;
    bus.req_index      = '0;
    bus.req_arg        = '0;
    bus.cmd_busy       = 1'b0;
    bus.cmd_complete   = 1'b0;
    bus.timeout_error  = 1'b0;
    bus.response_arg   = '0;
    bus.response_index = '0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [2:0] g;
    logic [2:0] exp_done;
`ifdef CMD_ARB_ROUND_ROBIN_EN
    g = v.gnt_rr;
`else
    g = v.gnt_fixed;
`endif
    exp_q.push_back(g);
    bus.req       = v.req;
    bus.req_index = v.req_index;
    bus.req_arg   = v.req_arg;
    step();
    check("vec_gnt", 64'(bus.gnt), 64'(g));
    check("vec_cmd_index", 64'(bus.cmd_index), 64'(sel_idx(v.req_index, g)));
    check("vec_cmd_arg", 64'(bus.cmd_arg), 64'(sel_arg(v.req_arg, g)));
    check("vec_new_cmd_hi", 64'(bus.new_cmd), 64'd1);
    repeat (v.busy_dly - 1) step();
    bus.cmd_busy = 1'b1;
    step();
    bus.cmd_busy = 1'b0;
    check("vec_new_cmd_lo", 64'(bus.new_cmd), 64'd0);
    check("vec_state_wait", 64'(dbg_state), 64'(ST_WAIT));
    repeat (v.cmpl_dly - 1) step();
    bus.cmd_complete   = v.cc;
    bus.timeout_error  = v.te;
    bus.response_index = v.resp_index;
    bus.response_arg   = v.resp_arg;
    step();
    bus.cmd_complete  = 1'b0;
    bus.timeout_error = 1'b0;
    exp_done = exp_q.pop_front();
    check("vec_done", 64'(bus.done), 64'(exp_done));
    check("vec_err", 64'(bus.err), 64'(v.te ? exp_done : 3'b000));
    check("vec_rsp_index", 64'(bus.rsp_index), 64'(v.resp_index));
    check("vec_rsp_arg", 64'(bus.rsp_arg), 64'(v.resp_arg));
    step();
    check("vec_done_clr", 64'(bus.done), 64'd0);
    check("vec_turnaround_gnt", 64'(bus.gnt), 64'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;

    vecs[0] = '{3'b111, {6'd23, 6'd12, 6'd5}, {32'h2222_2222, 32'h1111_1111, 32'h0000_0005},
                1, 3, 1'b1, 1'b0, 6'd1, 32'h0000_0101, 3'b010, 3'b001};
    vecs[1] = '{3'b111, {6'd23, 6'd12, 6'd5}, {32'h2222_2222, 32'h1111_1111, 32'h0000_0005},
                1, 3, 1'b1, 1'b0, 6'd2, 32'h0000_0202, 3'b010, 3'b010};
    vecs[2] = '{3'b111, {6'd23, 6'd12, 6'd5}, {32'h2222_2222, 32'h1111_1111, 32'h0000_0005},
                2, 2, 1'b1, 1'b0, 6'd3, 32'h0000_0303, 3'b010, 3'b100};
    vecs[3] = '{3'b111, {6'd23, 6'd12, 6'd5}, {32'h2222_2222, 32'h1111_1111, 32'h0000_0005},
                1, 1, 1'b1, 1'b0, 6'd4, 32'h0000_0404, 3'b010, 3'b001};
    vecs[4] = '{3'b001, {6'd0, 6'd0, 6'd17}, {32'h0, 32'h0, 32'hAAAA_AAAA},
                2, 10, 1'b1, 1'b0, 6'd17, 32'h0000_0900, 3'b001, 3'b001};
    vecs[5] = '{3'b010, {6'd0, 6'd12, 6'd0}, {32'h0, 32'h1234_5678, 32'h0},
                3, 4, 1'b1, 1'b0, 6'd12, 32'hCAFE_0012, 3'b010, 3'b010};
    vecs[6] = '{3'b100, {6'd23, 6'd0, 6'd0}, {32'h0000_0010, 32'h0, 32'h0},
                1, 2, 1'b1, 1'b1, 6'd23, 32'hDEAD_BEEF, 3'b100, 3'b100};
    vecs[7] = '{3'b101, {6'd40, 6'd0, 6'd33}, {32'h4444_0000, 32'h0, 32'h3333_0000},
                1, 1, 1'b0, 1'b1, 6'd63, 32'hFFFF_FFFF, 3'b100, 3'b001};
    vecs[8] = '{3'b110, {6'd50, 6'd49, 6'd0}, {32'h5050_5050, 32'h4949_4949, 32'h0},
                2, 2, 1'b1, 1'b0, 6'd49, 32'h0000_4949, 3'b010, 3'b010};
    vecs[9] = '{3'b101, {6'd7, 6'd0, 6'd8}, {32'h0707_0707, 32'h0, 32'h0808_0808},
                1, 2, 1'b1, 1'b0, 6'd7, 32'h0000_0007, 3'b100, 3'b100};

    // reset state
    drive_idle();
    reset = 1'b1;
    repeat (2) step();
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_new_cmd", 64'(bus.new_cmd), 64'd0);
    check("rst_cmd_index", 64'(bus.cmd_index), 64'd0);
    check("rst_cmd_arg", 64'(bus.cmd_arg), 64'd0);
    check("rst_rsp", 64'({bus.rsp_index, bus.rsp_arg}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;

    // first vector arbitrates on the first edge after release
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);
    bus.req = '0;
    step();

    // completion while idle is ignored
    bus.cmd_complete = 1'b1;
    step();
    bus.cmd_complete = 1'b0;
    check("idle_cmpl_state", 64'(dbg_state), 64'(ST_IDLE));
    check("idle_cmpl_done", 64'(bus.done), 64'd0);

    // winner drops req, loser changes index, completion during ISSUE ignored
    bus.req       = 3'b001;
    bus.req_index = {6'd10, 6'd0, 6'd9};
    bus.req_arg   = {32'h1010_1010, 32'h0, 32'h0909_0909};
    step();
    check("lose_gnt", 64'(bus.gnt), 64'b001);
    bus.req          = 3'b100;
    bus.req_index    = {6'd44, 6'd0, 6'd2};
    bus.req_arg      = {32'h4444_4444, 32'h0, 32'h0000_0002};
    bus.cmd_complete = 1'b1;
    step();
    bus.cmd_complete = 1'b0;
    check("issue_cmpl_state", 64'(dbg_state), 64'(ST_ISSUE));
    check("issue_cmpl_done", 64'(bus.done), 64'd0);
    check("lose_cmd_index_a", 64'(bus.cmd_index), 64'd9);
    check("lose_cmd_arg_a", 64'(bus.cmd_arg), 64'h0909_0909);
    bus.cmd_busy = 1'b1;
    step();
    bus.cmd_busy = 1'b0;
    check("lose_gnt_wait", 64'(bus.gnt), 64'b001);
    bus.req_index[17:12] = 6'd45;
    step();
    check("lose_cmd_index_b", 64'(bus.cmd_index), 64'd9);
    bus.cmd_complete   = 1'b1;
    bus.response_index = 6'd9;
    bus.response_arg   = 32'h0000_0909;
    step();
    bus.cmd_complete = 1'b0;
    check("lose_done", 64'(bus.done), 64'b001);
    check("lose_rsp", 64'({bus.rsp_index, bus.rsp_arg}), {26'd0, 6'd9, 32'h0000_0909});
    bus.req = '0;
    step();
    check("lose_gnt_clr", 64'(bus.gnt), 64'd0);

    // watchdog with cmd_busy never asserted
    bus.req            = 3'b010;
    bus.req_index      = {6'd0, 6'd21, 6'd0};
    bus.req_arg        = {32'h0, 32'h2121_2121, 32'h0};
    bus.response_index = 6'd55;
    bus.response_arg   = 32'h5555_5555;
    step();
    bus.req = '0;
    repeat (15) step();
    check("wd_new_cmd_hold", 64'(bus.new_cmd), 64'd1);
    check("wd_done_early", 64'(bus.done), 64'd0);
    step();
    check("wd_done", 64'(bus.done), 64'b010);
    check("wd_err", 64'(bus.err), 64'b010);
    check("wd_rsp_zero", 64'({bus.rsp_index, bus.rsp_arg}), 64'd0);
    check("wd_new_cmd_lo", 64'(bus.new_cmd), 64'd0);
    step();
    check("wd_done_clr", 64'(bus.done), 64'd0);
    check("wd_gnt_clr", 64'(bus.gnt), 64'd0);

    // completion on the expiry edge wins
    bus.req       = 3'b001;
    bus.req_index = {6'd0, 6'd0, 6'd3};
    step();
    bus.req      = '0;
    bus.cmd_busy = 1'b1;
    step();
    bus.cmd_busy = 1'b0;
    repeat (14) step();
    check("race_done_early", 64'(bus.done), 64'd0);
    bus.cmd_complete   = 1'b1;
    bus.response_index = 6'd3;
    bus.response_arg   = 32'h0000_3333;
    step();
    bus.cmd_complete = 1'b0;
    check("race_done", 64'(bus.done), 64'b001);
    check("race_err", 64'(bus.err), 64'd0);
    check("race_rsp", 64'({bus.rsp_index, bus.rsp_arg}), {26'd0, 6'd3, 32'h0000_3333});
    step();

    // reset in WAIT, pending request re-granted after release
    bus.req       = 3'b100;
    bus.req_index = {6'd30, 6'd0, 6'd0};
    bus.req_arg   = {32'h3030_3030, 32'h0, 32'h0};
    step();
    bus.cmd_busy = 1'b1;
    step();
    bus.cmd_busy = 1'b0;
    check("mid_state_wait", 64'(dbg_state), 64'(ST_WAIT));
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_cmd", 64'({bus.cmd_index, bus.cmd_arg}), 64'd0);
    check("mid_rst_flags", 64'({bus.done, bus.err, bus.new_cmd}), 64'd0);
    step();
    reset = 1'b0;
    step();
    check("regrant_gnt", 64'(bus.gnt), 64'b100);
    check("regrant_cmd_index", 64'(bus.cmd_index), 64'd30);
    bus.cmd_busy = 1'b1;
    step();
    bus.cmd_busy       = 1'b0;
    bus.cmd_complete   = 1'b1;
    bus.response_index = 6'd30;
    bus.response_arg   = 32'h0000_0030;
    step();
    bus.cmd_complete = 1'b0;
    check("regrant_done", 64'(bus.done), 64'b100);
    bus.req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
